vga_port_arbiter: RTL and testbench

- Shares the single VGA text-controller register port between two host-side requesters: A is the SPI command controller, B is a second host interface such as the UART command parser.
- Each requester drives the same strobe-style port it would drive into the VGA core directly (cmd, cursor address, data, cs_h, rl_wh, ready_h).
- The arbiter captures each one-cycle request, grants round-robin, and sequences exactly one VGA access at a time.
- It returns read data to the owning requester and guards against a hung core with a timeout.

---
 rtl/vga_port_pkg.sv | 28 ++
 rtl/vga_port_arbiter_if.sv | 25 ++
 rtl/vga_req_slot.sv | 80 ++++++++
 rtl/vga_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_vga_port_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_port_pkg.sv
// Shared definitions for the VGA register-port arbiter.
//   - VGA core command encodings (reads have bit 7 clear, writes set it)
//   - Arbiter state encoding
//   - Requester identifiers used for grant bookkeeping
package vga_port_pkg;

  localparam logic [7:0] R_STATUS  = 8'h00;
  localparam logic [7:0] R_CUR_AL  = 8'h02;
  localparam logic [7:0] R_CUR_AH  = 8'h03;
  localparam logic [7:0] R_CONTROL = 8'h04;
  localparam logic [7:0] W_STATUS  = 8'h80;
  localparam logic [7:0] W_DATA    = 8'h81;
  localparam logic [7:0] W_CUR_ADR = 8'h82;
  localparam logic [7:0] W_CONTROL = 8'h84;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/vga_port_arbiter_if.sv
// One requester's strobe-style VGA register port.
//   cmd/cur_adr/port/rl_wh : access description, qualified by cs_h
//   cs_h                   : one-cycle request strobe
//   rdata                  : read data returned to the requester
//   ready_h                : requester may strobe this cycle
// master = requester side, slave = arbiter side.
interface vga_port_arbiter_if;
  logic [7:0]  cmd;
  logic [10:0] cur_adr;
  logic [7:0]  port;
  logic        cs_h;
  logic        rl_wh;
  logic [7:0]  rdata;
  logic        ready_h;

  modport master (
    output cmd, cur_adr, port, cs_h, rl_wh,
    input  rdata, ready_h
  );

  modport slave (
    input  cmd, cur_adr, port, cs_h, rl_wh,
    output rdata, ready_h
  );
endinterface

// File: rtl/vga_req_slot.sv
// Per-requester capture slot.
//   i_clk, i_rst    : clock, synchronous active-high reset
//   req             : requester port (slave side)
//   i_vga_ready_h   : core ready, gates the requester's ready_h
//   i_clear         : access for this slot finished (done or timed out)
//   i_load_rdata    : latch i_rdata into the returned read-data register
//   i_rdata         : read data (core data or 8'hFF on timeout)
//   o_pend          : a captured access is waiting or in flight
//   o_cmd/o_cur_adr/o_wdata/o_rl_wh : captured access description
module vga_req_slot
  import vga_port_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  vga_port_arbiter_if.slave   req,
  input  logic                i_vga_ready_h,
  input  logic                i_clear,
  input  logic                i_load_rdata,
  input  logic [7:0]          i_rdata,
  output logic                o_pend,
  output logic [7:0]          o_cmd,
  output logic [10:0]         o_cur_adr,
  output logic [7:0]          o_wdata,
  output logic                o_rl_wh
);

  logic        pend_q, pend_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [10:0] adr_q, adr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rl_q, rl_d;
  logic        ready;
  logic        capture;

  always_comb begin
    // A requester may only strobe when it has nothing outstanding and the core is ready;
    // strobes at any other time are dropped.
    ready   = ~pend_q & i_vga_ready_h;
    capture = req.cs_h & ready;

    pend_d = pend_q;
    if (i_clear) pend_d = 1'b0;
    if (capture) pend_d = 1'b1;

    rdata_d = i_load_rdata ? i_rdata : rdata_q;

    cmd_d   = capture ? req.cmd     : cmd_q;
    adr_d   = capture ? req.cur_adr : adr_q;
    wdata_d = capture ? req.port    : wdata_q;
    rl_d    = capture ? req.rl_wh   : rl_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
    end
  end

  // Captured access fields are only meaningful while pend is set, so they carry no reset.
  always_ff @(posedge i_clk) begin
    cmd_q   <= cmd_d;
    adr_q   <= adr_d;
    wdata_q <= wdata_d;
    rl_q    <= rl_d;
  end

  assign req.ready_h = ready;
  assign req.rdata   = rdata_q;
  assign o_pend      = pend_q;
  assign o_cmd       = cmd_q;
  assign o_cur_adr   = adr_q;
  assign o_wdata     = wdata_q;
  assign o_rl_wh     = rl_q;

endmodule

// File: rtl/vga_port_arbiter.sv
// Round-robin arbiter sharing one VGA text-controller register port between
// two host requesters (A = SPI command controller, B = second host interface).
//   i_clk, i_rst      : clock, synchronous active-high reset
//   a_if, b_if        : requester ports (strobe, access fields, read data, ready)
//   o_vga_*           : register port towards the VGA core; cs_h high one cycle per access
//   i_vga_port        : core read data
//   i_vga_ready_h     : core ready
//   o_err_timeout     : one-cycle pulse when an access is abandoned
// Each access runs IDLE -> ISSUE -> HOLD -> WAIT -> IDLE; one access at a time.
module vga_port_arbiter
  import vga_port_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  vga_port_arbiter_if.slave   a_if,
  vga_port_arbiter_if.slave   b_if,
  output logic [7:0]          o_vga_cmd,
  output logic [10:0]         o_vga_cur_adr,
  output logic [7:0]          o_vga_port,
  output logic                o_vga_cs_h,
  output logic                o_vga_rl_wh,
  input  logic [7:0]          i_vga_port,
  input  logic                i_vga_ready_h,
  output logic                o_err_timeout
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic        pend_a, pend_b;
  logic [7:0]  cmd_a, cmd_b, wdata_a, wdata_b;
  logic [10:0] adr_a, adr_b;
  logic        rl_a, rl_b;

  state_t          state_q, state_d;
  req_id_t         grant_q, grant_d;
  req_id_t         last_q, last_d;
  req_id_t         pick;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [7:0]      vcmd_q, vcmd_d;
  logic [10:0]     vadr_q, vadr_d;
  logic [7:0]      vport_q, vport_d;
  logic            vrl_q, vrl_d;
  logic            vcs_q, vcs_d;
  logic            err_q, err_d;

  logic            done;
  logic            load_rd;
  logic [7:0]      rdata;
  logic            clear_a, clear_b, load_a, load_b;

  vga_req_slot u_slot_a (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .req           (a_if),
    .i_vga_ready_h (i_vga_ready_h),
    .i_clear       (clear_a),
    .i_load_rdata  (load_a),
    .i_rdata       (rdata),
    .o_pend        (pend_a),
    .o_cmd         (cmd_a),
    .o_cur_adr     (adr_a),
    .o_wdata       (wdata_a),
    .o_rl_wh       (rl_a)
  );

  vga_req_slot u_slot_b (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .req           (b_if),
    .i_vga_ready_h (i_vga_ready_h),
    .i_clear       (clear_b),
    .i_load_rdata  (load_b),
    .i_rdata       (rdata),
    .o_pend        (pend_b),
    .o_cmd         (cmd_b),
    .o_cur_adr     (adr_b),
    .o_wdata       (wdata_b),
    .o_rl_wh       (rl_b)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    vcmd_d  = vcmd_q;
    vadr_d  = vadr_q;
    vport_d = vport_q;
    vrl_d   = vrl_q;
    vcs_d   = 1'b0;
    err_d   = 1'b0;
    done    = 1'b0;
    load_rd = 1'b0;
    rdata   = i_vga_port;
    pick    = REQ_A;

    case (state_q)
      IDLE: begin
        if ((pend_a | pend_b) & i_vga_ready_h) begin
          // On contention the requester not served last wins.
          if (pend_a & pend_b) pick = (last_q == REQ_A) ? REQ_B : REQ_A;
          else if (pend_a)     pick = REQ_A;
          else                 pick = REQ_B;
          grant_d = pick;
          last_d  = pick;
          // Core-side fields are registered, so they are loaded here to be
          // presented during ISSUE together with cs_h.
          if (pick == REQ_A) begin
            vcmd_d  = cmd_a;
            vadr_d  = adr_a;
            vport_d = wdata_a;
            vrl_d   = rl_a;
          end else begin
            vcmd_d  = cmd_b;
            vadr_d  = adr_b;
            vport_d = wdata_b;
            vrl_d   = rl_b;
          end
          vcs_d   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = HOLD;
      // HOLD gives the core a cycle to drop ready before WAIT looks at it.
      HOLD:  state_d = WAIT;
      WAIT: begin
        if (i_vga_ready_h) begin
          done    = 1'b1;
          load_rd = ~vrl_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          done    = 1'b1;
          load_rd = ~vrl_q;
          rdata   = 8'hFF;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    clear_a = done & (grant_q == REQ_A);
    clear_b = done & (grant_q == REQ_B);
    load_a  = load_rd & (grant_q == REQ_A);
    load_b  = load_rd & (grant_q == REQ_B);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= REQ_A;
      last_q  <= REQ_B;
      cnt_q   <= '0;
      vcmd_q  <= 8'h00;
      vadr_q  <= 11'h000;
      vport_q <= 8'h00;
      vrl_q   <= 1'b0;
      vcs_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      vcmd_q  <= vcmd_d;
      vadr_q  <= vadr_d;
      vport_q <= vport_d;
      vrl_q   <= vrl_d;
      vcs_q   <= vcs_d;
      err_q   <= err_d;
    end
  end

  assign o_vga_cmd     = vcmd_q;
  assign o_vga_cur_adr = vadr_q;
  assign o_vga_port    = vport_q;
  assign o_vga_rl_wh   = vrl_q;
  assign o_vga_cs_h    = vcs_q;
  assign o_err_timeout = err_q;

endmodule

// File: tb/tb_vga_port_arbiter.sv
// Bench for vga_port_arbiter: a reactive core model, directed scenarios and a
// random phase, all checked against a transaction-level reference model and a
// scoreboard of expected core accesses.
module tb_vga_port_arbiter;
  import vga_port_pkg::*;

  localparam int TIMEOUT = 1024;
  localparam int TO_W    = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  o_vga_cmd, o_vga_port;
  logic [10:0] o_vga_cur_adr;
  logic        o_vga_cs_h, o_vga_rl_wh, o_err_timeout;
  logic [7:0]  i_vga_port = 8'h00;
  logic        i_vga_ready_h = 1'b1;

  vga_port_arbiter_if a_if();
  vga_port_arbiter_if b_if();

  vga_port_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .TO_W(TO_W)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .a_if          (a_if),
    .b_if          (b_if),
    .o_vga_cmd     (o_vga_cmd),
    .o_vga_cur_adr (o_vga_cur_adr),
    .o_vga_port    (o_vga_port),
    .o_vga_cs_h    (o_vga_cs_h),
    .o_vga_rl_wh   (o_vga_rl_wh),
    .i_vga_port    (i_vga_port),
    .i_vga_ready_h (i_vga_ready_h),
    .o_err_timeout (o_err_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    int          owner;
    logic [7:0]  cmd;
    logic [10:0] adr;
    logic [7:0]  port;
    bit          rl;
  } acc_t;

  acc_t        exp_q[$];
  int          grant_log[$];
  bit          m_pend[2];
  acc_t        m_slot[2];
  logic [7:0]  m_rd[2];
  int          m_last;     // requester served last (0 = A, 1 = B)
  int          m_owner;
  int          m_phase;    // 0 idle, 1 strobe cycle, 2 settle cycle, 3 waiting on the core
  int          m_waited;   // not-ready cycles spent waiting
  acc_t        m_core;     // what the core port currently shows
  bit          m_err;

  always @(posedge clk) begin
    bit   acc_a, acc_b, rdy;
    acc_t na, nb;
    m_err = 1'b0;
    if (rst) begin
      m_pend[0] = 0; m_pend[1] = 0;
      m_rd[0] = 8'h00; m_rd[1] = 8'h00;
      m_last = 1; m_owner = 0; m_phase = 0; m_waited = 0;
      m_core = '{owner: 0, cmd: 8'h00, adr: 11'h000, port: 8'h00, rl: 1'b0};
      exp_q.delete();
    end else begin
      rdy   = i_vga_ready_h;
      acc_a = a_if.cs_h && !m_pend[0] && rdy;
      acc_b = b_if.cs_h && !m_pend[1] && rdy;
      na = '{owner: 0, cmd: a_if.cmd, adr: a_if.cur_adr, port: a_if.port, rl: a_if.rl_wh};
      nb = '{owner: 1, cmd: b_if.cmd, adr: b_if.cur_adr, port: b_if.port, rl: b_if.rl_wh};
      case (m_phase)
        0: if ((m_pend[0] || m_pend[1]) && rdy) begin
             if (m_pend[0] && m_pend[1]) m_owner = 1 - m_last;
             else m_owner = m_pend[0] ? 0 : 1;
             m_last = m_owner;
             m_core = m_slot[m_owner];
             exp_q.push_back(m_slot[m_owner]);
             m_phase = 1;
           end
        1: m_phase = 2;
        2: begin m_phase = 3; m_waited = 0; end
        default: begin
          if (rdy) begin
            if (!m_core.rl) m_rd[m_owner] = i_vga_port;
            m_pend[m_owner] = 0;
            m_phase = 0;
          end else begin
            m_waited++;
            if (m_waited == TIMEOUT) begin
              if (!m_core.rl) m_rd[m_owner] = 8'hFF;
              m_pend[m_owner] = 0;
              m_err = 1'b1;
              m_phase = 0;
            end
          end
        end
      endcase
      if (acc_a) begin m_pend[0] = 1; m_slot[0] = na; end
      if (acc_b) begin m_pend[1] = 1; m_slot[1] = nb; end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit mon_en = 0;
  int err_seen = 0;
  int acc_seen = 0;

  always @(negedge clk) begin
    acc_t e;
    if (mon_en) begin
      check("cs_h", o_vga_cs_h, (m_phase == 1));
      check("err", o_err_timeout, m_err);
      check("ready_a", a_if.ready_h, (!m_pend[0] && i_vga_ready_h));
      check("ready_b", b_if.ready_h, (!m_pend[1] && i_vga_ready_h));
      check("a_port", a_if.rdata, m_rd[0]);
      check("b_port", b_if.rdata, m_rd[1]);
      check("vga_cmd_held", o_vga_cmd, m_core.cmd);
      check("vga_adr_held", o_vga_cur_adr, m_core.adr);
      check("vga_port_held", o_vga_port, m_core.port);
      check("vga_rl_held", o_vga_rl_wh, m_core.rl);
      if (o_err_timeout) err_seen++;
      if (o_vga_cs_h === 1'b1) begin
        acc_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_access", 1, 0);
        end else begin
          e = exp_q.pop_front();
          grant_log.push_back(e.owner);
          check("sb_cmd", o_vga_cmd, e.cmd);
          check("sb_adr", o_vga_cur_adr, e.adr);
          check("sb_port", o_vga_port, e.port);
          check("sb_rl", o_vga_rl_wh, e.rl);
        end
      end
    end
  end

  // ---------------- reactive VGA core ----------------
  int         core_delay = 0;
  logic [7:0] core_rd = 8'h00;
  bit         core_rand = 0;

  initial begin
    int hold;
    hold = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        hold = 0;
        i_vga_ready_h = 1'b1;
      end else if (o_vga_cs_h) begin
        if (core_rand) begin
          core_delay = $urandom_range(0, 6);
          core_rd    = 8'($urandom);
        end
        i_vga_port    = core_rd;
        hold          = core_delay;
        i_vga_ready_h = (hold == 0);
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) i_vga_ready_h = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic go(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(int who, logic [7:0] cmd, logic [10:0] adr, logic [7:0] dat, bit rl);
    if (who == 0) begin
      a_if.cmd = cmd; a_if.cur_adr = adr; a_if.port = dat; a_if.rl_wh = rl; a_if.cs_h = 1'b1;
    end else begin
      b_if.cmd = cmd; b_if.cur_adr = adr; b_if.port = dat; b_if.rl_wh = rl; b_if.cs_h = 1'b1;
    end
  endtask

  task automatic drop_cs();
    a_if.cs_h = 1'b0;
    b_if.cs_h = 1'b0;
  endtask

  task automatic strobe(int who, logic [7:0] cmd, logic [10:0] adr, logic [7:0] dat, bit rl);
    set_req(who, cmd, adr, dat, rl);
    go(1);
    drop_cs();
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while ((m_phase != 0 || m_pend[0] || m_pend[1]) && n < budget) begin
      go(1);
      n++;
    end
    if (n >= budget) check("idle_budget_expired", 1, 0);
    go(2);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_acc, base_err, first;
    logic [7:0] rcmd[4];
    a_if.cmd = 8'h00; a_if.cur_adr = 11'h000; a_if.port = 8'h00; a_if.rl_wh = 1'b0; a_if.cs_h = 1'b0;
    b_if.cmd = 8'h00; b_if.cur_adr = 11'h000; b_if.port = 8'h00; b_if.rl_wh = 1'b0; b_if.cs_h = 1'b0;
    rcmd[0] = W_DATA; rcmd[1] = R_CUR_AL; rcmd[2] = W_CONTROL; rcmd[3] = R_CONTROL;

    rst = 1'b1;
    go(1);
    mon_en = 1;
    go(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_vga_cmd", o_vga_cmd, 0);
    check("rst_vga_adr", o_vga_cur_adr, 0);
    check("rst_vga_port", o_vga_port, 0);
    check("rst_vga_cs", o_vga_cs_h, 0);
    check("rst_a_port", a_if.rdata, 0);
    check("rst_b_port", b_if.rdata, 0);
    check("rst_err", o_err_timeout, 0);
    check("rst_ready_a", a_if.ready_h, 1);
    go(1);

    // A writes W_DATA 0x41 with an always-ready core
    base_acc = acc_seen;
    core_delay = 0;
    strobe(0, W_DATA, 11'h010, 8'h41, 1'b1);
    wait_idle(50);
    check("wr_one_access", acc_seen - base_acc, 1);
    check("wr_a_port_unchanged", a_if.rdata, 8'h00);

    // B reads R_STATUS, core busy 5 cycles and returns 0x5A
    core_delay = 5; core_rd = 8'h5A;
    strobe(1, R_STATUS, 11'h000, 8'h00, 1'b0);
    wait_idle(50);
    check("rd_b_port", b_if.rdata, 8'h5A);
    check("rd_a_port_unchanged", a_if.rdata, 8'h00);

    // Three simultaneous A+B pairs: each pair starts with the one not served last
    core_delay = 1; core_rd = 8'h33;
    base_acc = grant_log.size();
    first = 1 - grant_log[grant_log.size() - 1];
    for (int p = 0; p < 3; p++) begin
      set_req(0, W_CUR_ADR, 11'(p), 8'(8'h10 + p), 1'b1);
      set_req(1, R_CUR_AH, 11'(p + 8), 8'(8'h20 + p), 1'b0);
      go(1);
      drop_cs();
      wait_idle(50);
    end
    check("rr_count", grant_log.size() - base_acc, 6);
    for (int i = 0; i < 6; i++)
      check("rr_order", grant_log[base_acc + i], (i % 2 == 0) ? first : 1 - first);

    // A W_CUR_ADR 0x7FF while B holds the port; A's repeat strobe is dropped
    core_delay = 0; core_rd = 8'hC3;
    base_acc = acc_seen;
    strobe(1, R_CUR_AL, 11'h123, 8'h00, 1'b0);
    go(1);
    strobe(0, W_CUR_ADR, 11'h7FF, 8'h00, 1'b1);
    strobe(0, W_CUR_ADR, 11'h7FF, 8'h00, 1'b1);
    wait_idle(50);
    check("adr_two_accesses", acc_seen - base_acc, 2);
    check("adr_b_port", b_if.rdata, 8'hC3);

    // A read against a stalled core times out, then B is served normally
    base_err = err_seen;
    core_delay = TIMEOUT + 80; core_rd = 8'h77;
    strobe(0, R_CONTROL, 11'h000, 8'h00, 1'b0);
    wait_idle(TIMEOUT + 40);
    check("to_err_once", err_seen - base_err, 1);
    check("to_a_port", a_if.rdata, 8'hFF);
    go(100);
    core_delay = 2; core_rd = 8'h99;
    strobe(1, R_STATUS, 11'h000, 8'h00, 1'b0);
    wait_idle(50);
    check("to_b_after", b_if.rdata, 8'h99);

    // Reset during WAIT aborts silently
    base_err = err_seen;
    core_delay = 40; core_rd = 8'h11;
    strobe(0, R_STATUS, 11'h000, 8'h00, 1'b0);
    go(6);
    rst = 1'b1;
    go(1);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_vga_cmd", o_vga_cmd, 0);
    check("mrst_vga_cs", o_vga_cs_h, 0);
    check("mrst_a_port", a_if.rdata, 0);
    check("mrst_b_port", b_if.rdata, 0);
    check("mrst_ready_a", a_if.ready_h, 1);
    check("mrst_ready_b", b_if.ready_h, 1);
    go(3);
    check("mrst_no_err", err_seen - base_err, 0);
    core_delay = 1; core_rd = 8'hE7;
    strobe(0, R_CUR_AL, 11'h000, 8'h00, 1'b0);
    wait_idle(50);
    check("mrst_a_after", a_if.rdata, 8'hE7);

    // Random traffic; strobes are issued regardless of ready_h
    core_rand = 1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0)
        set_req(0, rcmd[$urandom_range(0, 3)], 11'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0)
        set_req(1, rcmd[$urandom_range(0, 3)], 11'($urandom), 8'($urandom), 1'($urandom));
      go(1);
      drop_cs();
    end
    wait_idle(100);
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
